// File: rtl/sram_bus_pkg.sv
// Purpose: shared types and constants for the data-side SRAM-like bus.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: size encodings, response-queue entry struct, default depth/latency,
//           and a helper that converts a latency into the entry's initial countdown.
package sram_bus_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int DEF_QDEPTH = 2;
    localparam int DEF_LAT    = 2;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [2:0]  cnt;
    } resp_ent_t;

    // An entry is pushed with LAT-1 so that it becomes poppable LAT-1 edges
    // after acceptance; the pop edge registers data_ok, giving LAT in total.
    function automatic logic [2:0] lat_init(input int lat);
        return 3'(lat - 1);
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_queue.sv
// Purpose: in-order circular queue of outstanding responses with per-entry countdown.
// Latency: push visible at the next edge; head-ready is combinational from registered state.
// Backpressure: caller must not push when o_count == QDEPTH; pop only when o_head_rdy.
// Ports: clk/resetn (sync, active-low); i_push + i_push_ent enqueue; i_pop dequeues head;
//        o_count occupancy; o_head head entry; o_head_rdy head valid with cnt==0.
module resp_queue
    import sram_bus_pkg::*;
#(
    parameter  int QDEPTH = DEF_QDEPTH,
    localparam int CNT_W  = $clog2(QDEPTH) + 1,
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  resp_ent_t        i_push_ent,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output resp_ent_t        o_head,
    output logic             o_head_rdy
);

    resp_ent_t        r_ent [QDEPTH];
    logic [QDEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap modulo QDEPTH, which need not be a power of two in general.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_count    = r_count;
    assign o_head     = r_ent[r_rd_ptr];
    assign o_head_rdy = r_vld[r_rd_ptr] && (r_ent[r_rd_ptr].cnt == 3'd0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Every live entry ages, including ones stuck behind the head.
            for (int i = 0; i < QDEPTH; i++) begin
                if (r_vld[i] && (r_ent[i].cnt != 3'd0)) begin
                    r_ent[i].cnt <= r_ent[i].cnt - 3'd1;
                end
            end
            // The write slot is never live (no push when full), so this
            // cannot collide with the aging update above.
            if (i_push) begin
                r_ent[r_wr_ptr] <= i_push_ent;
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (i_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= next_ptr(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Purpose: SRAM-like data-bus responder with byte-enabled word memory and in-order responses.
// Latency: data_ok registered LAT cycles after address acceptance (later if queued behind head).
// Backpressure: addr_ok drops when hold is high or QDEPTH requests are outstanding; data_ok has none.
// Ports: clk/resetn (sync, active-low); req/wr/size/wstrb/addr/wdata request channel;
//        hold stalls acceptance; addr_ok accept strobe; data_ok/rdata response (rdata=0 for writes).
module data_sram_responder
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LAT    = DEF_LAT,
    parameter int QDEPTH = DEF_QDEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        hold,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
    logic              r_data_ok;
    logic [31:0]       r_rdata;

    logic [CNT_W-1:0]  w_count;
    logic              w_accept;
    logic              w_pop;
    logic [ADDR_W-1:0] w_idx;
    resp_ent_t         w_push_ent;
    resp_ent_t         w_head;

    // size and the byte-offset/upper address bits are deliberately ignored.
    logic w_unused;
    assign w_unused = &{1'b0, size, addr[31:ADDR_W+2], addr[1:0], w_head.wr, w_head.cnt};

    // Acceptance looks only at the registered count; a same-cycle pop is not
    // credited, keeping data_ok off the addr_ok path.
    assign addr_ok  = resetn & req & ~hold & (w_count < CNT_W'(QDEPTH));
    assign w_accept = req & addr_ok;
    assign w_idx    = addr[ADDR_W+1:2];

    // Read data is captured at acceptance, so later writes never alter an
    // already-queued read.
    always_comb begin
        w_push_ent       = '0;
        w_push_ent.wr    = wr;
        w_push_ent.rdata = wr ? 32'd0 : r_mem[w_idx];
        w_push_ent.cnt   = lat_init(LAT);
    end

    resp_queue #(
        .QDEPTH (QDEPTH)
    ) u_resp_queue (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_accept),
        .i_push_ent (w_push_ent),
        .i_pop      (w_pop),
        .o_count    (w_count),
        .o_head     (w_head),
        .o_head_rdy (w_pop)
    );

    // Memory is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_accept && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data_ok <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_data_ok <= w_pop;
            if (w_pop) begin
                r_rdata <= w_head.rdata;
            end
        end
    end

    assign data_ok = r_data_ok;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    localparam int LAT    = 2;
    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        hold = 1'b0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    data_sram_responder #(
        .ADDR_W (12),
        .LAT    (LAT),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .hold    (hold),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          edge_no;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every data_ok must match the oldest expected response, both in
    // data and in the edge at which it was registered.
    always @(negedge clk) begin
        if (data_ok === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_data_ok: got data_ok=1 rdata=0x%08h expected no response (cyc %0d)", rdata, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", rdata, e.d);
                check("resp_edge", 32'(cyc), 32'(e.edge_no + LAT));
            end
        end
    end

    // Issue one request and hold it until addr_ok; returns how many cycles it
    // waited. The expected response is queued at the acceptance edge.
    task automatic do_req(input logic i_wr, input logic [31:0] i_addr, input logic [31:0] i_wdata,
                          input logic [3:0] i_wstrb, input logic [31:0] exp_d, output int waits);
        bit   done;
        exp_t e;
        done  = 1'b0;
        waits = 0;
        @(negedge clk);
        req   = 1'b1;
        wr    = i_wr;
        addr  = i_addr;
        wdata = i_wdata;
        wstrb = i_wstrb;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (addr_ok === 1'b1) begin
                e.d       = exp_d;
                e.edge_no = cyc + 1;
                sb.push_back(e);
                done = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no addr_ok expected acceptance within 40 cycles (addr 0x%08h)", i_addr);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req   = 1'b0;
            wr    = 1'b0;
            wstrb = 4'h0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    int w;

    initial begin
        // Reset state: outputs low and addr_ok blocked even with req high.
        resetn = 1'b0;
        req    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_addr_ok", {31'd0, addr_ok}, 32'd0);
        check("reset_data_ok", {31'd0, data_ok}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle(1);

        // Write then read.
        do_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, w);
        idle(3);
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, w);
        // Upper address bits and byte offset are ignored.
        do_req(1'b0, 32'h1000_0102, 32'h0, 4'h0, 32'hDEAD_BEEF, w);
        idle(1);
        drain();

        // Byte strobes, and a zero-strobe write that must still respond.
        do_req(1'b1, 32'h0000_0200, 32'h1122_3344, 4'hF, 32'h0, w);
        do_req(1'b1, 32'h0000_0200, 32'hAAAA_AAAA, 4'b0100, 32'h0, w);
        do_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h11AA_3344, w);
        do_req(1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 4'b0000, 32'h0, w);
        do_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h11AA_3344, w);
        idle(1);
        drain();

        // Pipelined full: four back-to-back reads, third one stalls one cycle.
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, w);
        check("full_wait0", 32'(w), 32'd0);
        do_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h11AA_3344, w);
        check("full_wait1", 32'(w), 32'd0);
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, w);
        check("full_wait2", 32'(w), 32'd1);
        do_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h11AA_3344, w);
        check("full_wait3", 32'(w), 32'd0);
        idle(1);
        drain();

        // Hold: an outstanding read still returns while acceptance is held off.
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, w);
        fork
            begin
                @(negedge clk);
                hold = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("hold_addr_ok", {31'd0, addr_ok}, 32'd0);
                    @(negedge clk);
                end
                hold = 1'b0;
            end
            begin
                do_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h11AA_3344, w);
            end
        join
        check("hold_waits", 32'(w), 32'd3);
        idle(1);
        drain();

        // Read-before-write ordering.
        do_req(1'b1, 32'h0000_0300, 32'h0, 4'hF, 32'h0, w);
        idle(1);
        drain();
        do_req(1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h0, w);
        do_req(1'b1, 32'h0000_0300, 32'h0000_0055, 4'hF, 32'h0, w);
        do_req(1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h0000_0055, w);
        idle(1);
        drain();

        // Reset mid-flight: outstanding reads are discarded.
        do_req(1'b1, 32'h0000_0304, 32'h1234_5678, 4'hF, 32'h0, w);
        idle(1);
        drain();
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, w);
        do_req(1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h0000_0055, w);
        @(negedge clk);
        req    = 1'b0;
        resetn = 1'b0;
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        check("midrst_data_ok", {31'd0, data_ok}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        do_req(1'b0, 32'h0000_0304, 32'h0, 4'h0, 32'h1234_5678, w);
        check("midrst_wait", 32'(w), 32'd0);
        do_req(1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h0000_0055, w);
        check("midrst_wait2", 32'(w), 32'd0);
        idle(1);
        drain();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
